i2c_arbiter: RTL and testbench

Sequencer and arbiter that shares one I2C master (command/address/data/ready interface) between `NUM_REQ` requesters. It grants one requester at a time round-robin, issues the start command with that requester's address byte, data byte and speed bit, then tracks the master's `ready` handshake to completion. A watchdog recovers a hung master with the peripheral-reset command. It sits between the application-level clients and the I2C master, and is the only block that drives the master's command port.

---
 rtl/i2c_arb_pkg.sv | 22 ++
 rtl/rr_pick.sv | 31 +++
 rtl/i2c_arbiter.sv | 165 ++++++++++++++++
 tb/tb_i2c_arbiter.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_arb_pkg.sv
// Shared definitions for the I2C master arbiter: FSM encoding, command bit
// positions and speed-select values.
package i2c_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWaitBusy,
    StWaitDone,
    StRecover
  } arb_state_e;

  localparam int unsigned CMD_START = 0;
  localparam int unsigned CMD_RESET = 2;
  localparam int unsigned CMD_SPEED = 3;

  localparam logic SPEED_100K = 1'b0;
  localparam logic SPEED_400K = 1'b1;

  // Command word driven while the master's peripheral is being reset.
  localparam logic [3:0] CMD_RECOVER_WORD = 4'(1 << CMD_RESET);

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: picks the first set request strictly
// after the pointer, wrapping around.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          valid
);

  logic [IW-1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = IW'((32'(ptr) + k) % N);
      if (!valid && req[cand]) begin
        valid     = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_arbiter.sv
// Round-robin sequencer sharing one I2C master between NUM_REQ requesters,
// with start/ready handshake tracking and watchdog-driven master recovery.
module i2c_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned ACCEPT_TIMEOUT = 16,
  parameter int unsigned XFER_TIMEOUT   = 65535,
  parameter int unsigned RST_CYCLES     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_addr,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_fast,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   done,
  output logic [NUM_REQ-1:0]   err,
  output logic [3:0]           i2c_command,
  output logic [7:0]           i2c_address,
  output logic [7:0]           i2c_data,
  input  logic                 i2c_ready
);

  import i2c_arb_pkg::*;

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned CW = $clog2(XFER_TIMEOUT + 1);

  arb_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d, done_q, done_d, err_q, err_d;
  logic [3:0] cmd_q, cmd_d;
  logic [7:0] addr_q, addr_d, data_q, data_d;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IW-1:0]      pick_idx;
  logic               pick_valid;
  logic [7:0]         sel_addr, sel_data;
  logic               sel_fast;

  logic start_ok, accept_to, xfer_to, rec_end;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr_pick (
    .req   (req),
    .ptr   (ptr_q),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    sel_fast = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_gnt[i]) begin
        sel_addr = req_addr[8*i +: 8];
        sel_data = req_data[8*i +: 8];
        sel_fast = req_fast[i];
      end
    end
  end

  assign start_ok  = pick_valid && i2c_ready;
  // Compare against limit-1 so the transition edge lands exactly on the limit.
  assign accept_to = (cnt_q == CW'(ACCEPT_TIMEOUT - 1));
  assign xfer_to   = (cnt_q == CW'(XFER_TIMEOUT - 1));
  assign rec_end   = (cnt_q == CW'(RST_CYCLES - 1));

  // Next-state and watchdog counter.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:     if (start_ok) state_d = StWaitBusy;
      StWaitBusy: begin
        if (!i2c_ready) state_d = StWaitDone;
        else if (accept_to) state_d = StRecover;
      end
      StWaitDone: begin
        if (i2c_ready) state_d = StIdle;
        else if (xfer_to) state_d = StRecover;
      end
      StRecover:  if (rec_end) state_d = StIdle;
      default:    state_d = StIdle;
    endcase

    if (state_q == StIdle || state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q != {CW{1'b1}}) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Registered-output next values, derived from the current transition.
  always_comb begin
    gnt_d  = gnt_q;
    done_d = '0;
    err_d  = '0;
    cmd_d  = cmd_q;
    addr_d = addr_q;
    data_d = data_q;
    ptr_d  = ptr_q;

    if (state_q == StIdle && state_d == StWaitBusy) begin
      gnt_d            = pick_gnt;
      addr_d           = sel_addr;
      data_d           = sel_data;
      ptr_d            = pick_idx;
      cmd_d            = '0;
      cmd_d[CMD_START] = 1'b1;
      cmd_d[CMD_SPEED] = sel_fast ? SPEED_400K : SPEED_100K;
    end else if (state_q == StWaitBusy) begin
      cmd_d[CMD_START] = 1'b0;
    end

    if (state_d == StRecover && state_q != StRecover) begin
      cmd_d = CMD_RECOVER_WORD;
    end

    if (state_q != StIdle && state_d == StIdle) begin
      gnt_d = '0;
      cmd_d = '0;
      if (state_q == StWaitDone) done_d = gnt_q;
      else err_d = gnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ptr_q   <= IW'(NUM_REQ - 1);
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      cmd_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign gnt         = gnt_q;
  assign done        = done_q;
  assign err         = err_q;
  assign i2c_command = cmd_q;
  assign i2c_address = addr_q;
  assign i2c_data    = data_q;

endmodule

// File: tb/tb_i2c_arbiter.sv
// Scoreboard bench for i2c_arbiter: a behavioural I2C master model plus a
// completion monitor that pops expected transactions as done/err pulses appear.
module tb_i2c_arbiter;

  localparam int unsigned N = 4;
  localparam int MNormal = 0;
  localparam int MDeaf   = 1;
  localparam int MHang   = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [8*N-1:0] req_addr = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_fast = '0;
  logic [N-1:0]   gnt, done, err;
  logic [3:0]     i2c_command;
  logic [7:0]     i2c_address, i2c_data;
  logic           i2c_ready = 1'b1;

  always #5 clk = ~clk;

  i2c_arbiter #(
    .NUM_REQ        (N),
    .ACCEPT_TIMEOUT (16),
    .XFER_TIMEOUT   (100),
    .RST_CYCLES     (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_fast    (req_fast),
    .gnt         (gnt),
    .done        (done),
    .err         (err),
    .i2c_command (i2c_command),
    .i2c_address (i2c_address),
    .i2c_data    (i2c_data),
    .i2c_ready   (i2c_ready)
  );

  typedef struct {
    int         idx;
    bit         is_err;
    logic [7:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;

  int mode = MNormal;
  int busy_len = 3;
  int busy_cnt = 0;
  bit busy = 0;

  // Master model: drops ready right after seeing start, raises it busy_len cycles later.
  always @(negedge clk) begin
    if (!rst) begin
      i2c_ready = 1'b1;
      busy = 0;
      busy_cnt = 0;
    end else if (busy) begin
      if (mode != MHang && busy_cnt >= busy_len) begin
        i2c_ready = 1'b1;
        busy = 0;
      end
      busy_cnt++;
    end else if (i2c_command[0] && mode != MDeaf) begin
      i2c_ready = 1'b0;
      busy = 1;
      busy_cnt = 1;
    end
  end

  // Completion monitor.
  always @(negedge clk) begin
    if (rst && (done !== '0 || err !== '0)) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: done=%b err=%b but nothing pending", done, err);
      end else begin
        mon_e = sb_q.pop_front();
        if (done !== (mon_e.is_err ? 4'b0 : 4'(1 << mon_e.idx)) ||
            err !== (mon_e.is_err ? 4'(1 << mon_e.idx) : 4'b0)) begin
          bad++;
          $display("FAIL sb_result: done=%b err=%b expected idx=%0d is_err=%0d",
                   done, err, mon_e.idx, mon_e.is_err);
        end
        total++;
        if (gnt !== '0 || i2c_address !== mon_e.addr || i2c_data !== mon_e.data) begin
          bad++;
          $display("FAIL sb_end_state: gnt=%b addr=%h data=%h expected gnt=0 addr=%h data=%h",
                   gnt, i2c_address, i2c_data, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  task automatic wait_end(input int budget, output int n, output bit seen);
    n = 0;
    seen = 0;
    while (!seen && n < budget) begin
      @(negedge clk);
      n++;
      if (done !== '0 || err !== '0) seen = 1;
    end
  endtask

  task automatic wait_gnt(input int budget, output bit seen);
    int n = 0;
    seen = 0;
    while (!seen && n < budget) begin
      @(negedge clk);
      n++;
      if (gnt !== '0) seen = 1;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    req = '0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    mode = MNormal;
    rst = 1'b1;
  endtask

  task automatic push_exp(input int idx, input bit is_err);
    exp_t e;
    e.idx = idx;
    e.is_err = is_err;
    e.addr = req_addr[8*idx +: 8];
    e.data = req_data[8*idx +: 8];
    sb_q.push_back(e);
  endtask

  task automatic test_reset();
    int n;
    bit seen;
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (gnt !== '0) begin bad++; $display("FAIL reset_gnt: got %b want 0", gnt); end
    total++;
    if (done !== '0 || err !== '0) begin
      bad++; $display("FAIL reset_done_err: got done=%b err=%b want 0", done, err);
    end
    total++;
    if (i2c_command !== 4'b0) begin
      bad++; $display("FAIL reset_cmd: got %b want 0000", i2c_command);
    end
    total++;
    if (i2c_address !== 8'h0 || i2c_data !== 8'h0) begin
      bad++; $display("FAIL reset_addr_data: got %h/%h want 00/00", i2c_address, i2c_data);
    end
    req_addr[8*2 +: 8] = 8'hA0;
    req_data[8*2 +: 8] = 8'h5C;
    req_fast = 4'b0100;
    req = 4'b0100;
    mode = MNormal;
    busy_len = 20;
    push_exp(2, 0);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (gnt !== 4'b0100 || i2c_command !== 4'b1001) begin
      bad++; $display("FAIL first_grant: gnt=%b cmd=%b want 0100/1001", gnt, i2c_command);
    end
    @(negedge clk);
    total++;
    if (i2c_command !== 4'b1000) begin
      bad++; $display("FAIL start_one_cycle: cmd=%b want 1000", i2c_command);
    end
    wait_end(60, n, seen);
    total++;
    if (!seen || n != 20 || done !== 4'b0100) begin
      bad++; $display("FAIL first_done: seen=%0d wait=%0d done=%b want 1/20/0100", seen, n, done);
    end
    req = '0;
    @(negedge clk);
    total++;
    if (gnt !== '0) begin bad++; $display("FAIL after_done_gnt: got %b want 0", gnt); end
  endtask

  task automatic test_round_robin();
    int order[5] = '{0, 1, 2, 3, 0};
    int n;
    bit seen;
    apply_reset();
    busy_len = 3;
    req_fast = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      req_addr[8*i +: 8] = 8'h40 + 8'(2 * i);
      req_data[8*i +: 8] = 8'h10 * 8'(i + 1);
    end
    for (int i = 0; i < 5; i++) push_exp(order[i], 0);
    req = 4'b1111;
    wait_gnt(10, seen);
    total++;
    if (!seen) begin
      bad++; $display("FAIL rr_first_gnt: no grant within 10 cycles, want grant");
      return;
    end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (gnt !== 4'(1 << order[i]) ||
          i2c_command !== {req_fast[order[i]], 3'b001}) begin
        bad++;
        $display("FAIL rr_grant_%0d: gnt=%b cmd=%b want gnt=%b cmd=%b", i, gnt, i2c_command,
                 4'(1 << order[i]), {req_fast[order[i]], 3'b001});
      end
      wait_end(30, n, seen);
      total++;
      if (!seen) begin
        bad++; $display("FAIL rr_done_%0d: no completion within 30 cycles", i);
        return;
      end
      if (i == 4) req = '0;
      @(negedge clk);
    end
    total++;
    if (gnt !== '0) begin bad++; $display("FAIL rr_idle_end: gnt=%b want 0", gnt); end
  endtask

  task automatic test_accept_timeout();
    bit seen;
    apply_reset();
    mode = MDeaf;
    req_addr[7:0] = 8'h90;
    req_data[7:0] = 8'h01;
    req_fast = 4'b0101;
    push_exp(0, 1);
    req = 4'b0001;
    wait_gnt(10, seen);
    total++;
    if (!seen || i2c_command !== 4'b1001) begin
      bad++; $display("FAIL acc_grant: seen=%0d cmd=%b want 1/1001", seen, i2c_command);
    end
    repeat (15) @(negedge clk);
    total++;
    if (i2c_command !== 4'b1000) begin
      bad++; $display("FAIL acc_cycle15: cmd=%b want 1000", i2c_command);
    end
    @(negedge clk);
    total++;
    if (i2c_command !== 4'b0100 || gnt !== 4'b0001) begin
      bad++; $display("FAIL acc_recover_entry: cmd=%b gnt=%b want 0100/0001", i2c_command, gnt);
    end
    repeat (3) @(negedge clk);
    total++;
    if (i2c_command !== 4'b0100) begin
      bad++; $display("FAIL acc_recover_hold: cmd=%b want 0100", i2c_command);
    end
    @(negedge clk);
    total++;
    if (err !== 4'b0001 || done !== '0 || i2c_command !== 4'b0 || gnt !== '0) begin
      bad++; $display("FAIL acc_err: err=%b done=%b cmd=%b gnt=%b want 0001/0/0000/0",
                      err, done, i2c_command, gnt);
    end
    req = '0;
  endtask

  task automatic test_xfer_timeout();
    bit seen;
    apply_reset();
    mode = MHang;
    req_addr[15:8] = 8'h22;
    req_data[15:8] = 8'h77;
    req_fast = 4'b0101;
    push_exp(1, 1);
    req = 4'b0010;
    wait_gnt(10, seen);
    total++;
    if (!seen || i2c_command !== 4'b0001) begin
      bad++; $display("FAIL xfer_grant: seen=%0d cmd=%b want 1/0001", seen, i2c_command);
    end
    repeat (100) @(negedge clk);
    total++;
    if (i2c_command !== 4'b0000 || gnt !== 4'b0010) begin
      bad++; $display("FAIL xfer_cycle100: cmd=%b gnt=%b want 0000/0010", i2c_command, gnt);
    end
    @(negedge clk);
    total++;
    if (i2c_command !== 4'b0100) begin
      bad++; $display("FAIL xfer_recover_entry: cmd=%b want 0100", i2c_command);
    end
    repeat (4) @(negedge clk);
    total++;
    if (err !== 4'b0010 || gnt !== '0) begin
      bad++; $display("FAIL xfer_err: err=%b gnt=%b want 0010/0", err, gnt);
    end
    req = '0;
  endtask

  task automatic test_hold_on_change();
    int n;
    bit seen;
    apply_reset();
    busy_len = 10;
    req_addr[7:0] = 8'h50;
    req_data[7:0] = 8'h33;
    push_exp(0, 0);
    req = 4'b0001;
    wait_gnt(10, seen);
    repeat (4) @(negedge clk);
    req_data[7:0] = 8'hEE;
    req_addr[7:0] = 8'h00;
    req = '0;
    @(negedge clk);
    total++;
    if (!seen || i2c_data !== 8'h33 || i2c_address !== 8'h50) begin
      bad++; $display("FAIL hold_latched: seen=%0d addr=%h data=%h want 1/50/33",
                      seen, i2c_address, i2c_data);
    end
    wait_end(40, n, seen);
    total++;
    if (!seen || done !== 4'b0001 || err !== '0) begin
      bad++; $display("FAIL hold_done: seen=%0d done=%b err=%b want 1/0001/0", seen, done, err);
    end
    @(negedge clk);
    total++;
    if (gnt !== '0) begin bad++; $display("FAIL hold_no_regrant: gnt=%b want 0", gnt); end
  endtask

  task automatic test_async_reset();
    int n;
    bit seen;
    bit spurious = 0;
    apply_reset();
    busy_len = 30;
    req_addr[23:16] = 8'hC4;
    req_data[23:16] = 8'hD5;
    req = 4'b0100;
    wait_gnt(10, seen);
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    total++;
    if (!seen || gnt !== '0 || i2c_command !== '0 || i2c_address !== '0 || i2c_data !== '0) begin
      bad++; $display("FAIL async_reset_outputs: seen=%0d gnt=%b cmd=%b addr=%h data=%h want 1/0",
                      seen, gnt, i2c_command, i2c_address, i2c_data);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done !== '0 || err !== '0) spurious = 1;
    end
    total++;
    if (spurious) begin bad++; $display("FAIL async_no_pulse: got done/err during reset, want none"); end
    req_addr[15:8] = 8'h61;
    req_data[15:8] = 8'h62;
    req_fast = 4'b0101;
    req = 4'b1010;
    push_exp(1, 0);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (gnt !== 4'b0010 || i2c_command !== 4'b0001) begin
      bad++; $display("FAIL async_first_grant: gnt=%b cmd=%b want 0010/0001", gnt, i2c_command);
    end
    wait_end(60, n, seen);
    total++;
    if (!seen || done !== 4'b0010) begin
      bad++; $display("FAIL async_done: seen=%0d done=%b want 1/0010", seen, done);
    end
    req = '0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_accept_timeout();
    test_xfer_timeout();
    test_hold_on_change();
    test_async_reset();
    total++;
    if (sb_q.size() != 0) begin
      bad++; $display("FAIL sb_drain: %0d expected completions never seen, want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
